// File: rtl/hex_keypad_pkg.sv
// Shared state encodings, column constants and row encoder for the hex keypad scanner.
// Pure definitions: no latency, no flow control.
package hex_keypad_pkg;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] DEBOUNCE = 3'd1;
  localparam logic [2:0] SCAN     = 3'd2;
  localparam logic [2:0] REPORT   = 3'd3;
  localparam logic [2:0] RELEASE  = 3'd4;

  localparam logic [3:0] COLS_ALL = 4'b1111;

  // Lowest set row bit wins; an empty row vector maps to row 0.
  function automatic logic [1:0] row_encode(input logic [3:0] r);
    logic [1:0] idx;
    idx = 2'd0;
    if (r[0])      idx = 2'd0;
    else if (r[1]) idx = 2'd1;
    else if (r[2]) idx = 2'd2;
    else if (r[3]) idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/keypad_wait_counter.sv
// Shared wait counter: clear has priority, counts on enable, holds at term (never wraps).
// done is combinational from count/term; no flow control.
module keypad_wait_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] term,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  assign done = (count == term);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !done) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hex_keypad_scan_ctrl.sv
// 4x4 keypad column scanner: debounce, per-column settle/sample, encode, report, release.
// Key valid 4+DEBOUNCE+(col+1)*SETTLE cycles after a pin press; holds the code until key_ready.
module hex_keypad_scan_ctrl
  import hex_keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SETTLE_CYCLES   = 4,
  parameter int CNT_W           = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       s_row,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       scan_busy
);

  localparam logic [CNT_W-1:0] DEB_TC = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SET_TC = CNT_W'(SETTLE_CYCLES - 1);

  logic [2:0]       state, state_nxt;
  logic [1:0]       col_idx, col_idx_nxt;
  logic             cnt_clear, cnt_en, cnt_done, capture;
  logic [CNT_W-1:0] cnt_term, count;

  keypad_wait_counter #(.CNT_W(CNT_W)) u_wait (
    .clock  (clock),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .term   (cnt_term),
    .count  (count),
    .done   (cnt_done)
  );

  always_comb begin
    state_nxt   = state;
    col_idx_nxt = col_idx;
    cnt_clear   = 1'b0;
    cnt_en      = 1'b0;
    capture     = 1'b0;
    cnt_term    = DEB_TC;
    case (state)
      IDLE: begin
        if (s_row) begin
          state_nxt = DEBOUNCE;
          cnt_clear = 1'b1;
        end
      end
      DEBOUNCE: begin
        if (!s_row) begin
          state_nxt = IDLE;
          cnt_clear = 1'b1;
        end else if (cnt_done) begin
          state_nxt   = SCAN;
          col_idx_nxt = 2'd0;
          cnt_clear   = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      SCAN: begin
        cnt_term = SET_TC;
        if (!cnt_done) begin
          cnt_en = 1'b1;
        end else begin
          cnt_clear = 1'b1;
          if (s_row) begin
            state_nxt = REPORT;
            capture   = 1'b1;
          end else if (col_idx == 2'd3) begin
            // Key let go before any column matched: drop silently.
            state_nxt = IDLE;
          end else begin
            col_idx_nxt = col_idx + 2'd1;
          end
        end
      end
      REPORT: begin
        if (key_valid && key_ready) begin
          state_nxt = RELEASE;
          cnt_clear = 1'b1;
        end
      end
      RELEASE: begin
        if (s_row) begin
          cnt_clear = 1'b1;
        end else if (cnt_done) begin
          state_nxt = IDLE;
          cnt_clear = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_clear = 1'b1;
      end
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      col_idx   <= 2'd0;
      col       <= COLS_ALL;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      scan_busy <= 1'b0;
    end else begin
      state     <= state_nxt;
      col_idx   <= col_idx_nxt;
      scan_busy <= (state_nxt != IDLE);
      key_valid <= (state_nxt == REPORT);
      if (capture) begin
        key_code <= {row_encode(row), col_idx};
      end
      if (state_nxt == SCAN || state_nxt == REPORT) begin
        col <= 4'(4'b0001 << col_idx_nxt);
      end else begin
        col <= COLS_ALL;
      end
    end
  end

endmodule

// File: tb/tb_hex_keypad_scan_ctrl.sv
// Bench: keypad matrix + 3-flop row synchronizer environment, table vectors, corner sequences, random presses.
module tb_hex_keypad_scan_ctrl;

  localparam int DEB = 16;
  localparam int SET = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       s_row;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       scan_busy;

  logic [15:0] pressed = '0;   // bit index = key code = row*4+col
  logic [2:0]  sync = '0;

  int checks = 0;
  int errors = 0;

  int xfers = 0, pulses = 0, unstable = 0;
  logic [3:0] colq[$];
  logic       vprev = 1'b0;
  logic [3:0] cprev = '0, colprev = 4'hF;

  hex_keypad_scan_ctrl #(.DEBOUNCE_CYCLES(DEB), .SETTLE_CYCLES(SET), .CNT_W(5)) dut (
    .clock     (clock),
    .reset     (reset),
    .s_row     (s_row),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .scan_busy (scan_busy)
  );

  always #5 clock = ~clock;

  always_comb begin
    for (int r = 0; r < 4; r++) row[r] = |(pressed[r*4 +: 4] & col);
  end

  always @(posedge clock) sync <= {sync[1:0], |row};
  assign s_row = sync[2];

  always @(negedge clock) begin
    if (key_valid && key_ready) xfers <= xfers + 1;
    if (key_valid && !vprev) pulses <= pulses + 1;
    if (key_valid && vprev && key_code != cprev) unstable <= unstable + 1;
    if (col != 4'hF && col != colprev) colq.push_back(col);
    vprev   <= key_valid;
    cprev   <= key_code;
    colprev <= col;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: lowest column holding any pressed key, then lowest row within it.
  function automatic logic [3:0] model_code(input logic [15:0] keys);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys[r*4+c]) return 4'(r*4 + c);
    return 4'd0;
  endfunction

  task automatic press(input logic [15:0] keys, input int rdy_dly, input logic [3:0] exp, input string name);
    int lat, n, x0, p0, u0, c, lo;
    logic [31:0] seq, seq_exp;
    logic bad;
    colq.delete();
    x0 = xfers; p0 = pulses; u0 = unstable;
    key_ready = 1'b0;
    pressed = keys;
    lat = 0;
    while (!key_valid && lat < 300) begin tick(); lat++; end
    check({name, " valid_seen"}, key_valid, 1'b1);
    c  = int'(exp[1:0]);
    lo = 3 + DEB + (c + 1) * SET;
    checks++;
    if (lat < lo || lat > lo + 2) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles required %0d..%0d", name, lat, lo, lo + 2);
    end
    check({name, " code"}, key_code, exp);
    seq = '0;
    foreach (colq[i]) seq |= 32'(colq[i]) << (4 * i);
    seq_exp = '0;
    for (int i = 0; i <= c; i++) seq_exp |= (32'h1 << i) << (4 * i);
    check({name, " col_steps"}, seq, seq_exp);
    bad = 1'b0;
    for (int i = 0; i < rdy_dly; i++) begin
      tick();
      if (!key_valid || key_code != exp) bad = 1'b1;
    end
    check({name, " held_while_not_ready"}, bad, 1'b0);
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    check({name, " valid_drop"}, key_valid, 1'b0);
    check({name, " col_after_xfer"}, col, 4'hF);
    for (int i = 0; i < 30; i++) tick();
    pressed = '0;
    n = 0;
    while (scan_busy && n < 150) begin tick(); n++; end
    check({name, " back_to_idle"}, scan_busy, 1'b0);
    check({name, " idle_col"}, col, 4'hF);
    check({name, " transfers"}, 32'(xfers - x0), 32'd1);
    check({name, " pulses"}, 32'(pulses - p0), 32'd1);
    check({name, " stable_code"}, 32'(unstable - u0), 32'd0);
    for (int i = 0; i < 5; i++) tick();
  endtask

  typedef struct {
    logic [15:0] keys;
    int          rdy;
    logic [3:0]  code;
  } vec_t;

  vec_t vt[6];

  initial begin
    logic bad_v, bad_c;
    int n, p0;
    logic [15:0] k;

    vt[0] = '{16'h0040, 0,  4'h6};
    vt[1] = '{16'h8000, 50, 4'hF};
    vt[2] = '{16'h0220, 0,  4'h5};
    vt[3] = '{16'h0001, 2,  4'h0};
    vt[4] = '{16'h4080, 1,  4'hE};
    vt[5] = '{16'h0008, 3,  4'h3};

    reset = 1'b1;
    key_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b0;
    tick();
    check("reset col", col, 4'hF);
    check("reset valid", key_valid, 1'b0);
    check("reset busy", scan_busy, 1'b0);
    check("reset code", key_code, 4'h0);

    for (int i = 0; i < 6; i++)
      press(vt[i].keys, vt[i].rdy, vt[i].code, $sformatf("vec%0d", i));

    // Bounce: high 5, low 2, high 5 never completes debounce.
    p0 = pulses; bad_v = 1'b0; bad_c = 1'b0;
    pressed = 16'h0040; for (int i = 0; i < 5; i++) tick();
    pressed = '0;       for (int i = 0; i < 2; i++) tick();
    pressed = 16'h0040; for (int i = 0; i < 5; i++) tick();
    pressed = '0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (key_valid) bad_v = 1'b1;
      if (col != 4'hF) bad_c = 1'b1;
    end
    check("bounce valid", bad_v, 1'b0);
    check("bounce col", bad_c, 1'b0);
    check("bounce pulses", 32'(pulses - p0), 32'd0);
    check("bounce idle", scan_busy, 1'b0);

    // Release mid-scan: key in column 3 let go as scanning starts.
    colq.delete(); p0 = pulses;
    pressed = 16'h0008;
    n = 0;
    while (col != 4'b0001 && n < 100) begin tick(); n++; end
    check("midscan reached_scan", col, 4'b0001);
    pressed = '0;
    n = 0;
    while (scan_busy && n < 100) begin tick(); n++; end
    check("midscan idle", scan_busy, 1'b0);
    check("midscan col_steps", {colq.size() == 4 ? colq[3] : 4'h0}, 4'b1000);
    check("midscan pulses", 32'(pulses - p0), 32'd0);
    for (int i = 0; i < 5; i++) tick();

    // Reset while reporting discards the pending code.
    pressed = 16'h0400;
    n = 0;
    while (!key_valid && n < 300) begin tick(); n++; end
    check("rst_report valid", key_valid, 1'b1);
    check("rst_report code", key_code, 4'hA);
    reset = 1'b1; pressed = '0;
    tick();
    reset = 1'b0;
    check("rst_report valid_off", key_valid, 1'b0);
    check("rst_report col", col, 4'hF);
    check("rst_report busy", scan_busy, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    press(16'h0008, 0, 4'h3, "after_reset");

    // Random one- or two-key presses against the reference model.
    for (int t = 0; t < 12; t++) begin
      k = 16'h1 << $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) k |= 16'h1 << $urandom_range(0, 15);
      press(k, int'($urandom_range(0, 8)), model_code(k), $sformatf("rand%0d_%04h", t, k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_keypad_scan_ctrl.md
Name: hex_keypad_scan_ctrl

Overview:
Column-scan controller for the 4x4 hex keypad. It drives the column lines and watches the synchronized OR-of-rows flag. It debounces a press, scans one column at a time to locate the key, then encodes it as a 4-bit hex code. The code goes to the consumer over a valid/ready handshake. The block sits between the keypad pins and the row synchronizer on one side, and the display/command logic on the other.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive cycles s_row must hold a level before a press or release is accepted (min 1).
- SETTLE_CYCLES, 4: wait cycles after each column change before s_row is sampled. Must be >= 3 to cover the synchronizer's 3-cycle latency.
- CNT_W, 5: width of the shared wait counter. Must satisfy 2^CNT_W > max(DEBOUNCE_CYCLES, SETTLE_CYCLES).

Ports:
- clock, input, 1: system clock, rising edge.
- reset, input, 1: synchronous, active-high reset.
- s_row, input, 1: synchronized OR of the row lines (3-cycle latency from the pins).
- row, input, 4: raw row lines, one-hot when a single key is pressed. Sampled only in SCAN, at the end of settle.
- col, output, 4: column drive. 4'b1111 = all columns, else one-hot.
- key_code, output, 4: encoded key, {row_idx[1:0], col_idx[1:0]}.
- key_valid, output, 1: key_code is valid.
- key_ready, input, 1: consumer accepts; a transfer occurs when key_valid & key_ready.
- scan_busy, output, 1: high in every state except IDLE.

Behaviour:
- Reset (synchronous, active-high; applies anywhere, including mid-scan or mid-report): state=IDLE, col=4'b1111, key_code=0, key_valid=0, scan_busy=0, counter=0, column index=0. A pending undelivered code is discarded.
- States: IDLE, DEBOUNCE, SCAN, REPORT, RELEASE.
- IDLE: col=1111. If s_row=1, clear the counter and go to DEBOUNCE.
- DEBOUNCE: col=1111.
  - If s_row=0 in any cycle, return to IDLE (bounce rejected).
  - When the counter reaches DEBOUNCE_CYCLES-1 with s_row=1, set column index=0 and go to SCAN.
- SCAN: col = one-hot(column index), so col[0] is first.
  - The counter runs 0..SETTLE_CYCLES-1. Sample only when it equals SETTLE_CYCLES-1.
  - Sample with s_row=1: latch key_code = {enc(row), col_idx} and go to REPORT with key_valid=1. enc takes the lowest set row bit; if row==0 at sample time, use row_idx=0.
  - Sample with s_row=0 and col_idx<3: increment the column index, clear the counter, stay in SCAN.
  - Sample with s_row=0 and col_idx==3: key released mid-scan. Go to IDLE with no output.
- REPORT: key_valid=1. key_code is held stable until the transfer.
  - col stays on the found column; this does not affect the handshake.
  - On key_valid & key_ready: key_valid=0 on the next cycle, go to RELEASE.
  - Stays here indefinitely while key_ready=0; releasing the key does not cancel the report.
- RELEASE: col=1111.
  - Require s_row=0 for DEBOUNCE_CYCLES consecutive cycles, then go to IDLE.
  - Any s_row=1 clears the counter (held key, no auto-repeat).
- Latency: a press stable from cycle 0 at the pins gives key_valid=1 no earlier than 3 + DEBOUNCE_CYCLES + (col_idx+1)*SETTLE_CYCLES cycles later.
- Exactly one key_valid pulse/transfer per physical press.
- Multiple keys in the same column: the lowest row wins. Multiple keys across columns: the lowest column wins.
- Counter never wraps. It is cleared on every state or column change.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package hex_keypad_pkg holds:
  - the state enum localparams (IDLE=0, DEBOUNCE=1, SCAN=2, REPORT=3, RELEASE=4, 3-bit);
  - COLS_ALL=4'b1111;
  - a row_encode function (one-hot-to-index, lowest bit priority).
- One natural sub-module: keypad_wait_counter. It is a CNT_W-bit counter with clear/enable and a terminal-count compare input, and is shared by debounce, settle and release.
- The existing synchronizer is instantiated at the top level, not inside this block.

Test Plan:
- Key 0x6 (row=0010, col[2]), held 200 cycles, key_ready=1 → col steps 0001→0010→0100; one key_valid pulse with key_code=4'h6; after release and DEBOUNCE, return to IDLE with col=1111.
- Key 0xF (row=1000, col[3]), key_ready=0 for 50 cycles then 1 → key_valid held with key_code=4'hF stable; exactly one transfer; no second valid while the key stays held.
- Bounce: s_row high for 5 cycles, low 2, high 5 (DEBOUNCE_CYCLES=16) → never leaves IDLE/DEBOUNCE; col stays 1111; key_valid stays 0.
- Key released during SCAN before its column is reached → returns to IDLE after col=1000 is sampled; key_valid never asserts.
- Keys 0x5 and 0x9 pressed together (row bits 1 and 2, col[1]) → key_code=4'h5.
- reset asserted for 1 cycle while in REPORT → next cycle key_valid=0, col=1111, scan_busy=0; a fresh press of 0x3 then reports 4'h3.
